// File: rtl/demorgan_pkg.sv
// Shared types and the golden truth function for the demorgan gate unit self-test.
package demorgan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VEC_W = 2;

    // Expected unit outputs in the order {nA, nB, nAandnB, n_AorB, nAornB, n_AandB}.
    function automatic logic [5:0] golden(input logic a, input logic b);
        golden = {~a, ~b, (~a & ~b), ~(a | b), (~a | ~b), ~(a & b)};
    endfunction

endpackage

// File: rtl/demorgan_checker.sv
// Combinational compare of the six observed unit outputs against the golden set.
module demorgan_checker
    import demorgan_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic nA,
    input  logic nB,
    input  logic nAandnB,
    input  logic n_AorB,
    input  logic nAornB,
    input  logic n_AandB,
    output logic mismatch
);

    logic [5:0] observed_s;

    // Any bit differing from the golden vector flags the whole check cycle.
    always_comb begin
        observed_s = {nA, nB, nAandnB, n_AorB, nAornB, n_AandB};
        mismatch   = 1'b0;
        if (observed_s != golden(a, b)) begin
            mismatch = 1'b1;
        end else begin
            mismatch = 1'b0;
        end
    end

endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// Self-test sequencer: drives all four (A,B) vectors, waits a settle window,
// checks the unit outputs and keeps a saturating error count plus first failure.
module demorgan_sweep_ctrl
    import demorgan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ITERATIONS    = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             nA,
    input  logic             nB,
    input  logic             nAandnB,
    input  logic             n_AorB,
    input  logic             nAornB,
    input  logic             n_AandB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             fail_valid
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ITER_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [ERR_W-1:0]  ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_ZERO    = {ERR_W{1'b0}};
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_LAST   = ITER_W'(ITERATIONS - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST    = {VEC_W{1'b1}};

    state_t             state_r;
    logic [VEC_W-1:0]   vec_r;
    logic [ITER_W-1:0]  iter_r;
    logic [SET_W-1:0]   settle_r;
    logic               a_r;
    logic               b_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [ERR_W-1:0]   err_r;
    logic [1:0]         ffv_r;
    logic               fv_r;

    logic               mismatch_s;
    logic [ERR_W-1:0]   err_next_s;
    logic [VEC_W-1:0]   vec_next_s;

    demorgan_checker u_checker (
        .a        (a_r),
        .b        (b_r),
        .nA       (nA),
        .nB       (nB),
        .nAandnB  (nAandnB),
        .n_AorB   (n_AorB),
        .nAornB   (nAornB),
        .n_AandB  (n_AandB),
        .mismatch (mismatch_s)
    );

    // Next error count (saturating) and next vector index for the check cycle.
    always_comb begin
        err_next_s = err_r;
        vec_next_s = vec_r + VEC_W'(1);
        if (mismatch_s && (err_r != ERR_MAX)) begin
            err_next_s = err_r + ERR_W'(1);
        end else begin
            err_next_s = err_r;
        end
    end

    // Sequencer FSM with all outputs registered; reset aborts any sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            vec_r    <= {VEC_W{1'b0}};
            iter_r   <= {ITER_W{1'b0}};
            settle_r <= {SET_W{1'b0}};
            a_r      <= 1'b0;
            b_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            err_r    <= ERR_ZERO;
            ffv_r    <= 2'b00;
            fv_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r  <= SETTLE;
                        vec_r    <= {VEC_W{1'b0}};
                        iter_r   <= {ITER_W{1'b0}};
                        settle_r <= {SET_W{1'b0}};
                        a_r      <= 1'b0;
                        b_r      <= 1'b0;
                        busy_r   <= 1'b1;
                        pass_r   <= 1'b0;
                        err_r    <= ERR_ZERO;
                        ffv_r    <= 2'b00;
                        fv_r     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_r == SETTLE_LAST) begin
                        settle_r <= {SET_W{1'b0}};
                        state_r  <= CHECK;
                    end else begin
                        settle_r <= settle_r + SET_W'(1);
                    end
                end
                CHECK: begin
                    err_r <= err_next_s;
                    if (mismatch_s && !fv_r) begin
                        fv_r  <= 1'b1;
                        ffv_r <= {a_r, b_r};
                    end
                    vec_r <= vec_next_s;
                    a_r   <= vec_next_s[1];
                    b_r   <= vec_next_s[0];
                    if (vec_r == VEC_LAST) begin
                        if (iter_r == ITER_LAST) begin
                            iter_r  <= {ITER_W{1'b0}};
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            pass_r  <= (err_next_s == ERR_ZERO);
                        end else begin
                            iter_r  <= iter_r + ITER_W'(1);
                            state_r <= SETTLE;
                        end
                    end else begin
                        state_r <= SETTLE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    a_r     <= 1'b0;
                    b_r     <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    a_r     <= 1'b0;
                    b_r     <= 1'b0;
                end
            endcase
        end
    end

    assign A              = a_r;
    assign B              = b_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_count      = err_r;
    assign first_fail_vec = ffv_r;
    assign fail_valid     = fv_r;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: two instances (default and ERR_W=2/ITERATIONS=2),
// a modelled gate unit with injectable faults, a timeline reference model and
// directed plus random stimulus.
module tb_demorgan_sweep_ctrl;

    localparam int S_P[2]  = '{2, 2};
    localparam int I_P[2]  = '{1, 2};
    localparam int EW_P[2] = '{4, 2};

    typedef struct {
        int t;      // edges since the start-sampling edge, -1 when idle
        int ab;
        int busy;
        int done;
        int pass;
        int err;
        int fv;
        int ffv;
    } model_t;

    logic       clk;
    logic       rst_v[2];
    logic       start_v[2];
    logic       a_w[2];
    logic       b_w[2];
    logic [5:0] unit_w[2];
    logic       busy_w[2];
    logic       done_w[2];
    logic       pass_w[2];
    logic [3:0] err0_w;
    logic [1:0] err1_w;
    logic [1:0] ffv_w[2];
    logic       fv_w[2];
    int         fault[2];
    model_t     mdl[2];
    bit         chk_en;
    int         n_checks;
    int         n_fail;

    // Gate unit under test with a fault mode: 0 good, 1 n_AorB stuck-0,
    // 2 nAornB stuck-1, 3 every output inverted.
    function automatic logic [5:0] unit_out(input logic a, input logic b, input int mode);
        logic [5:0] g;
        g = {~a, ~b, (~a & ~b), ~(a | b), (~a | ~b), ~(a & b)};
        case (mode)
            1:       g[2] = 1'b0;
            2:       g[1] = 1'b1;
            3:       g = ~g;
            default: g = g;
        endcase
        return g;
    endfunction

    // Which vectors each fault mode corrupts.
    function automatic bit fails(input int vec, input int mode);
        return (mode == 3) || (mode == 1 && vec == 0) || (mode == 2 && vec == 3);
    endfunction

    // Timeline model: everything follows from the number of edges since start.
    function automatic model_t step(input model_t m, input bit rst, input bit st,
                                    input int s, input int it, input int ew, input int mode);
        model_t r;
        int n;
        int vec;
        r = m;
        n = 4 * it * (s + 1);
        if (rst) begin
            r.t = -1; r.ab = 0; r.busy = 0; r.done = 0; r.pass = 0;
            r.err = 0; r.fv = 0; r.ffv = 0;
            return r;
        end
        if (r.t < 0) begin
            r.done = 0;
            if (st) begin
                r.t = 0; r.ab = 0; r.busy = 1; r.pass = 0;
                r.err = 0; r.fv = 0; r.ffv = 0;
            end
            return r;
        end
        r.t = r.t + 1;
        if (r.t == n + 1) begin
            r.t = -1;
            r.done = 0;
            return r;
        end
        if (r.t % (s + 1) == 0) begin
            vec = (r.t / (s + 1) - 1) % 4;
            if (fails(vec, mode)) begin
                if (r.err < (1 << ew) - 1) r.err = r.err + 1;
                if (r.fv == 0) begin
                    r.fv = 1;
                    r.ffv = vec;
                end
            end
        end
        if (r.t == n) begin
            r.done = 1; r.pass = (r.err == 0) ? 1 : 0; r.busy = 0; r.ab = 0;
        end else begin
            r.ab = (r.t / (s + 1)) % 4;
        end
        return r;
    endfunction

    task automatic check(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got %0d required %0d (t=%0t)", d, name, act, exp, $time);
        end
    endtask

    assign unit_w[0] = unit_out(a_w[0], b_w[0], fault[0]);
    assign unit_w[1] = unit_out(a_w[1], b_w[1], fault[1]);

    demorgan_sweep_ctrl u0 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .A(a_w[0]), .B(b_w[0]),
        .nA(unit_w[0][5]), .nB(unit_w[0][4]), .nAandnB(unit_w[0][3]),
        .n_AorB(unit_w[0][2]), .nAornB(unit_w[0][1]), .n_AandB(unit_w[0][0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err0_w),
        .first_fail_vec(ffv_w[0]), .fail_valid(fv_w[0])
    );

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(2), .ITERATIONS(2), .ERR_W(2)) u1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .A(a_w[1]), .B(b_w[1]),
        .nA(unit_w[1][5]), .nB(unit_w[1][4]), .nAandnB(unit_w[1][3]),
        .n_AorB(unit_w[1][2]), .nAornB(unit_w[1][1]), .n_AandB(unit_w[1][0]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err1_w),
        .first_fail_vec(ffv_w[1]), .fail_valid(fv_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model on every rising edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mdl[d] <= step(mdl[d], rst_v[d], start_v[d], S_P[d], I_P[d], EW_P[d], fault[d]);
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check("AB",         d, int'({a_w[d], b_w[d]}), mdl[d].ab);
                check("busy",       d, int'(busy_w[d]), mdl[d].busy);
                check("done",       d, int'(done_w[d]), mdl[d].done);
                check("pass",       d, int'(pass_w[d]), mdl[d].pass);
                check("err_count",  d, (d == 0) ? int'(err0_w) : int'(err1_w), mdl[d].err);
                check("fail_valid", d, int'(fv_w[d]), mdl[d].fv);
                check("first_fail", d, int'(ffv_w[d]), mdl[d].ffv);
            end
        end
    end

    // Pulse start on instance d, return the start-to-done latency (-1 on timeout).
    task automatic sweep(input int d, input int mode, output int lat);
        fault[d] = mode;
        @(posedge clk); #1;
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done_w[d]) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) check("done_timeout", d, lat, 0);
    endtask

    function automatic int err_of(input int d);
        return (d == 0) ? int'(err0_w) : int'(err1_w);
    endfunction

    initial begin
        int lat;
        int dones;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        fault[0] = 0;
        fault[1] = 0;
        for (int d = 0; d < 2; d++) begin
            rst_v[d]   = 1'b1;
            start_v[d] = 1'b0;
            mdl[d]     = '{-1, 0, 0, 0, 0, 0, 0, 0};
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        @(negedge clk);
        check("reset_err", 0, int'(err0_w), 0);
        check("reset_busy", 0, int'(busy_w[0]), 0);

        // Golden unit: 12-cycle sweep, clean result.
        sweep(0, 0, lat);
        check("lat_golden", 0, lat, 12);
        check("pass_golden", 0, int'(pass_w[0]), 1);
        check("err_golden", 0, err_of(0), 0);
        check("fv_golden", 0, int'(fv_w[0]), 0);

        // n_AorB stuck-at-0: only vector 00 fails.
        sweep(0, 1, lat);
        check("err_sa0", 0, err_of(0), 1);
        check("ffv_sa0", 0, int'(ffv_w[0]), 0);
        check("pass_sa0", 0, int'(pass_w[0]), 0);

        // nAornB stuck-at-1: only vector 11 fails.
        sweep(0, 2, lat);
        check("err_sa1", 0, err_of(0), 1);
        check("ffv_sa1", 0, int'(ffv_w[0]), 3);
        check("fv_sa1", 0, int'(fv_w[0]), 1);

        // Two iterations, all outputs inverted, 2-bit counter saturates.
        sweep(1, 3, lat);
        check("lat_sat", 1, lat, 24);
        check("err_sat", 1, err_of(1), 3);
        check("ffv_sat", 1, int'(ffv_w[1]), 0);
        check("pass_sat", 1, int'(pass_w[1]), 0);

        // Reset during the second CHECK cycle aborts the sweep.
        @(posedge clk); #1;
        fault[0] = 3;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_v[0] = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        @(negedge clk);
        check("abort_busy", 0, int'(busy_w[0]), 0);
        check("abort_ab", 0, int'({a_w[0], b_w[0]}), 0);
        check("abort_err", 0, err_of(0), 0);
        check("abort_fv", 0, int'(fv_w[0]), 0);
        sweep(0, 0, lat);
        check("lat_after_abort", 0, lat, 12);
        check("pass_after_abort", 0, int'(pass_w[0]), 1);

        // start pulses in SETTLE and in the DONE cycle are ignored.
        @(posedge clk); #1;
        dones = 0;
        for (int k = 0; k <= 40; k++) begin
            start_v[0] = (k == 0 || k == 2 || k == 13) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            if (done_w[0]) dones++;
        end
        start_v[0] = 1'b0;
        check("single_done", 0, dones, 1);

        // Random start/reset/fault traffic on both instances.
        for (int c = 0; c < 900; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                start_v[d] = ($urandom % 4 == 0) ? 1'b1 : 1'b0;
                rst_v[d]   = ($urandom % 97 == 0) ? 1'b1 : 1'b0;
                if (c % 150 == 0) fault[d] = int'($urandom % 4);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            rst_v[d]   = 1'b0;
        end
        repeat (60) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
